// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and a saturating counter helper
// for the ALU response checker.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [4:0] sat_inc(input logic [4:0] value);
        return (value == 5'd31) ? value : value + 5'd1;
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU under test: expected result and carry.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] exp_out,
    output logic       exp_carry
);

    logic [8:0]  sum;
    logic [15:0] product;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign product   = {8'd0, a} * {8'd0, b};
    // The carry is defined as the adder carry regardless of the operation.
    assign exp_carry = sum[8];

    always_comb begin
        exp_out = 8'd0;
        case (sel)
            OP_ADD:  exp_out = sum[7:0];
            OP_SUB:  exp_out = a - b;
            OP_MUL:  exp_out = product[7:0];
            // Division by zero is never compared; return a defined value anyway.
            OP_DIV:  exp_out = (b == 8'd0) ? 8'hFF : a / b;
            OP_SHL:  exp_out = {a[6:0], 1'b0};
            OP_SHR:  exp_out = {1'b0, a[7:1]};
            OP_ROL:  exp_out = {a[6:0], a[7]};
            OP_ROR:  exp_out = {a[0], a[7:1]};
            OP_AND:  exp_out = a & b;
            OP_OR:   exp_out = a | b;
            OP_XOR:  exp_out = a ^ b;
            OP_NOR:  exp_out = ~(a | b);
            OP_NAND: exp_out = ~(a & b);
            OP_XNOR: exp_out = ~(a ^ b);
            OP_GT:   exp_out = (a > b) ? 8'd1 : 8'd0;
            OP_EQ:   exp_out = (a == b) ? 8'd1 : 8'd0;
            default: exp_out = 8'd0;
        endcase
    end

endmodule

// File: rtl/alu_response_checker.sv
// Accepts NUM_OPS ALU samples per run, compares each against a reference model
// one cycle after acceptance, and reports pass/fail with counters.
module alu_response_checker
    import alu_pkg::*;
#(
    parameter int NUM_OPS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    input  logic [7:0] alu_out,
    input  logic       carry_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] chk_count,
    output logic [4:0] err_count,
    output logic [4:0] skip_count,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_sel
);

    localparam logic [4:0] OPS_LIMIT = 5'(NUM_OPS);

    state_t     state, next_state;
    logic [4:0] acc_count;
    logic       start_run;
    logic       transfer;

    logic       stage_valid;
    logic [7:0] stage_a, stage_b, stage_out;
    logic [3:0] stage_sel;
    logic       stage_carry;

    logic [7:0] exp_out;
    logic       exp_carry;
    logic       stage_skip;
    logic       stage_mismatch;

    alu_ref_model u_ref (
        .a         (stage_a),
        .b         (stage_b),
        .sel       (stage_sel),
        .exp_out   (exp_out),
        .exp_carry (exp_carry)
    );

    assign transfer       = in_valid & in_ready;
    assign stage_skip     = (stage_sel == OP_DIV) && (stage_b == 8'd0);
    assign stage_mismatch = (stage_out != exp_out) || (stage_carry != exp_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        start_run  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CHECK;
                    start_run  = 1'b1;
                end
            end
            CHECK: begin
                busy     = 1'b1;
                in_ready = (acc_count < OPS_LIMIT);
                // Last sample has been accepted and now sits in the compare stage.
                if (stage_valid && (acc_count == OPS_LIMIT))
                    next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == 5'd0);
                if (start) begin
                    next_state = CHECK;
                    start_run  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_count        <= 5'd0;
            stage_valid      <= 1'b0;
            stage_a          <= 8'd0;
            stage_b          <= 8'd0;
            stage_sel        <= 4'd0;
            stage_out        <= 8'd0;
            stage_carry      <= 1'b0;
            chk_count        <= 5'd0;
            err_count        <= 5'd0;
            skip_count       <= 5'd0;
            first_fail_valid <= 1'b0;
            first_fail_sel   <= 4'd0;
        end else if (start_run) begin
            acc_count        <= 5'd0;
            stage_valid      <= 1'b0;
            chk_count        <= 5'd0;
            err_count        <= 5'd0;
            skip_count       <= 5'd0;
            first_fail_valid <= 1'b0;
        end else begin
            stage_valid <= transfer;
            if (transfer) begin
                acc_count   <= acc_count + 5'd1;
                stage_a     <= a;
                stage_b     <= b;
                stage_sel   <= sel;
                stage_out   <= alu_out;
                stage_carry <= carry_out;
            end
            if (stage_valid) begin
                if (stage_skip) begin
                    skip_count <= sat_inc(skip_count);
                end else begin
                    chk_count <= sat_inc(chk_count);
                    if (stage_mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_sel   <= stage_sel;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/alu_response_checker.md
ALU_RESPONSE_CHECKER -- requirements
Module: alu_response_checker

Interface
REQ-001 Parameter: NUM_OPS, default 16, number of accepted samples per check run (legal 1..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  begins a run when the block is in IDLE or DONE.
REQ-005 in_valid  input  1  sample present on a/b/sel/alu_out/carry_out.
REQ-006 in_ready  output  1  checker accepts a sample this cycle.
REQ-007 a, b  input  8 each  operands applied to the ALU under test.
REQ-008 sel  input  4  ALU operation select.
REQ-009 alu_out  input  8  ALU result under test.
REQ-010 carry_out  input  1  ALU carry under test.
REQ-011 busy  output  1  high in CHECK state.
REQ-012 done  output  1  high in DONE state.
REQ-013 pass  output  1  high in DONE when err_count = 0.
REQ-014 chk_count  output  5  samples compared in the current run.
REQ-015 err_count  output  5  mismatching samples in the current run.
REQ-016 skip_count  output  5  samples excluded from comparison.
REQ-017 first_fail_valid / first_fail_sel  output  1 / 4  sel of the first mismatching sample.

Function
REQ-018 Expected result per sel: 0 a+b, 1 a-b, 2 a*b (low 8 bits), 3 a/b, 4 a<<1, 5 a>>1, 6 rotate-left-1, 7 rotate-right-1, 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR, 14 (a>b)?1:0, 15 (a==b)?1:0; all results 8 bits wide, truncated.
REQ-019 Expected carry SHALL be bit 8 of the 9-bit sum {0,a}+{0,b} for every sel.
REQ-020 A sample is a mismatch if alu_out or carry_out differs from expected.
REQ-021 sel=3 with b=0: sample SHALL be accepted, counted in skip_count, not in chk_count or err_count.
REQ-022 FSM states IDLE, CHECK, DONE; IDLE->CHECK and DONE->CHECK on start; CHECK->DONE on the edge that registers the NUM_OPS-th result.
REQ-023 Entering CHECK SHALL clear chk_count, err_count, skip_count and first_fail_valid.
REQ-024 start while in CHECK SHALL be ignored.
REQ-025 in_ready SHALL be high only in CHECK while fewer than NUM_OPS samples have been accepted; transfer = in_valid & in_ready.
REQ-026 Latency: sample accepted at edge k SHALL update counters at edge k+1 (one registered compare stage).
REQ-027 Back-to-back transfers every cycle SHALL be supported without loss.
REQ-028 first_fail_sel SHALL capture only the first mismatch of a run; later mismatches leave it unchanged.
REQ-029 in_valid while in_ready low SHALL have no effect.
REQ-030 Counters SHALL saturate at 31.
REQ-031 done, pass and all counters SHALL hold in DONE until start or rst.

Reset
REQ-032 rst SHALL force IDLE, in_ready=0, busy=0, done=0, pass=0, all counts 0, first_fail_valid=0, first_fail_sel=0, compare stage empty.
REQ-033 rst asserted mid-run SHALL discard the in-flight sample; no counter updates after deassertion until a new start.

Structure
REQ-034 Package alu_pkg SHALL hold the 16 sel opcode constants and the FSM state type.
REQ-035 Expected-value computation SHALL be a combinational sub-module alu_ref_model (a, b, sel -> exp_out, exp_carry).

Verification
REQ-036 start, then 16 samples a=0x0F, b=0x0A, sel=0..15 with correct results (0x19,0x05,0x96,0x01,0x1E,0x07,0x1E,0x87,0x0A,0x0F,0x05,0xF0,0xF5,0xFA,0x01,0x00), carry 0 -> done=1, pass=1, chk_count=16, err_count=0.
REQ-037 Same run, sel=7 reports alu_out=0x07 -> err_count=1, first_fail_valid=1, first_fail_sel=7, pass=0.
REQ-038 a=0xFF, b=0x01, sel=0, alu_out=0x00, carry_out=0 -> mismatch counted (expected carry 1).
REQ-039 sel=3, b=0x00, any alu_out -> skip_count=1, chk_count and err_count unchanged.
REQ-040 in_valid held high every cycle -> 16 transfers in 16 consecutive cycles, in_ready low after the 16th, done one cycle later.
REQ-041 rst pulsed after 5 transfers -> all outputs at reset values; new start yields a clean 16-sample run.
